// File: rtl/shift_src_sequencer.sv
// Purpose: picks a shift function code and amount from NCH source channels, latches them
//   on start, then drives the shift register through one LOAD cycle and block or bit-step SHIFT cycles.
// Latency: LOAD one cycle after start; DONE after 1 (short path), 2 (block) or 1+amt (step) more cycles.
// Backpressure: none; start is honoured only in IDLE and is dropped otherwise (no queuing).
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   src            - NCH flattened DW-bit channels, channel i = src[i*DW +: DW]
//   start          - request, sampled only while idle
//   func_sel       - channel whose bits [2:0] give the function code
//   amt_sel        - channel whose bits [AMTW-1:0] give the shift amount
//   step_mode      - 0 = single block shift, 1 = one bit per cycle
//   shift_func     - function code to the shift register (registered)
//   shift_n        - shift amount to the shift register (registered)
//   busy/done/err  - status back to the control unit (registered)
module shift_src_sequencer #(
  parameter int NCH  = 4,
  parameter int DW   = 32,
  parameter int AMTW = 5,
  localparam int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*DW-1:0] src,
  input  logic              start,
  input  logic [SELW-1:0]   func_sel,
  input  logic [SELW-1:0]   amt_sel,
  input  logic              step_mode,
  output logic [2:0]        shift_func,
  output logic [AMTW-1:0]   shift_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [2:0] F_NOP     = 3'b000;
  localparam logic [2:0] F_LOAD    = 3'b001;
  localparam logic [2:0] F_ILLEGAL = 3'b111;

  state_t          state;
  logic [2:0]      fcode;
  logic [AMTW-1:0] amt;
  logic            mode;
  logic [AMTW-1:0] rem;
  logic            err_flag;

  logic [DW-1:0]   fsrc;
  logic [DW-1:0]   asrc;
  logic            unused_src_bits;

  // Channel select: any select value without a matching channel falls back to channel 0.
  always_comb begin
    fsrc = src[0 +: DW];
    asrc = src[0 +: DW];
    for (int i = 1; i < NCH; i++) begin
      if (func_sel == SELW'(i)) fsrc = src[i*DW +: DW];
      if (amt_sel == SELW'(i))  asrc = src[i*DW +: DW];
    end
  end

  // Only the low bits of each selected channel carry information.
  assign unused_src_bits = ^{fsrc[DW-1:3], asrc[DW-1:AMTW]};

  // Outputs are registered alongside the state: each transition writes the
  // outputs belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      fcode      <= '0;
      amt        <= '0;
      mode       <= 1'b0;
      rem        <= '0;
      err_flag   <= 1'b0;
      shift_func <= F_NOP;
      shift_n    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      shift_func <= F_NOP;
      shift_n    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fcode      <= fsrc[2:0];
            amt        <= asrc[AMTW-1:0];
            mode       <= step_mode;
            rem        <= asrc[AMTW-1:0];
            state      <= LOAD;
            shift_func <= F_LOAD;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (fcode == F_ILLEGAL) begin
            // err_flag is set for bookkeeping; the DONE-cycle err output is written directly here.
            err_flag <= 1'b1;
            state    <= DONE;
            done     <= 1'b1;
            err      <= 1'b1;
          end else if (fcode == F_NOP || fcode == F_LOAD || amt == '0) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= err_flag;
          end else begin
            state      <= SHIFT;
            shift_func <= fcode;
            shift_n    <= mode ? AMTW'(1) : amt;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          // rem starts at amt (>= 1 here), so step mode spends exactly amt cycles in SHIFT.
          if (!mode || rem == AMTW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= err_flag;
          end else begin
            rem        <= rem - AMTW'(1);
            shift_func <= fcode;
            shift_n    <= AMTW'(1);
            busy       <= 1'b1;
          end
        end
        DONE: begin
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_src_sequencer.sv
module tb_shift_src_sequencer;

  localparam int NCH  = 3;
  localparam int DW   = 32;
  localparam int AMTW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH*DW-1:0] src;
  logic              start;
  logic [1:0]        func_sel;
  logic [1:0]        amt_sel;
  logic              step_mode;
  logic [2:0]        shift_func;
  logic [AMTW-1:0]   shift_n;
  logic              busy;
  logic              done;
  logic              err;

  int n_cmp = 0;
  int n_err = 0;

  shift_src_sequencer #(.NCH(NCH), .DW(DW), .AMTW(AMTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .start      (start),
    .func_sel   (func_sel),
    .amt_sel    (amt_sel),
    .step_mode  (step_mode),
    .shift_func (shift_func),
    .shift_n    (shift_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setch(input int i, input logic [DW-1:0] v);
    src[i*DW +: DW] = v;
  endtask

  task automatic chk(input string tag, input logic [2:0] f, input logic [4:0] n,
                     input logic b, input logic d, input logic e);
    logic [10:0] got;
    logic [10:0] exp;
    got = {shift_func, shift_n, busy, done, err};
    exp = {f, n, b, d, e};
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got func=%b n=%0d busy=%b done=%b err=%b, expected func=%b n=%0d busy=%b done=%b err=%b",
             tag, got[10:8], got[7:3], got[2], got[1], got[0], f, n, b, d, e);
    end
  endtask

  initial begin
    // Reset held for two edges with start high.
    reset = 1'b0; start = 1'b1; src = '0;
    func_sel = 2'd0; amt_sel = 2'd0; step_mode = 1'b0;
    tick(); tick();
    chk("reset", 3'b000, 5'd0, 0, 0, 0);
    reset = 1'b1; start = 1'b0;
    tick();
    chk("reset_release_idle", 3'b000, 5'd0, 0, 0, 0);

    // Block shift left by 5: ch2 gives 010, ch1 gives 5.
    setch(0, 32'h0000_0000); setch(1, 32'hABCD_0025); setch(2, 32'hFFFF_FFFA);
    func_sel = 2'd2; amt_sel = 2'd1; step_mode = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("blk_load", 3'b001, 5'd0, 1, 0, 0);
    tick();
    chk("blk_shift", 3'b010, 5'd5, 1, 0, 0);
    tick();
    chk("blk_done", 3'b000, 5'd0, 0, 1, 0);
    tick();
    chk("blk_idle", 3'b000, 5'd0, 0, 0, 0);

    // Step rotate left by 3, inputs disturbed after capture.
    setch(0, 32'h0000_0006); setch(1, 32'h1234_5663);
    func_sel = 2'd0; amt_sel = 2'd1; step_mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("step_load", 3'b001, 5'd0, 1, 0, 0);
    func_sel = 2'd2; amt_sel = 2'd2; step_mode = 1'b0;
    setch(0, 32'h0000_0003); setch(1, 32'h0000_0010);
    tick();
    chk("step_shift1", 3'b110, 5'd1, 1, 0, 0);
    setch(2, 32'h0000_0001);
    tick();
    chk("step_shift2", 3'b110, 5'd1, 1, 0, 0);
    tick();
    chk("step_shift3", 3'b110, 5'd1, 1, 0, 0);
    tick();
    chk("step_done", 3'b000, 5'd0, 0, 1, 0);
    tick();
    chk("step_idle", 3'b000, 5'd0, 0, 0, 0);

    // Zero amount: LOAD straight to DONE.
    setch(0, 32'h0000_0003); setch(1, 32'h0000_0020);
    func_sel = 2'd0; amt_sel = 2'd1; step_mode = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("zero_load", 3'b001, 5'd0, 1, 0, 0);
    tick();
    chk("zero_done", 3'b000, 5'd0, 0, 1, 0);
    tick();
    chk("zero_idle", 3'b000, 5'd0, 0, 0, 0);

    // Illegal code: err pulses with done for one cycle.
    setch(0, 32'h0000_0007); setch(1, 32'h0000_0004);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("ill_load", 3'b001, 5'd0, 1, 0, 0);
    tick();
    chk("ill_done", 3'b000, 5'd0, 0, 1, 1);
    tick();
    chk("ill_idle", 3'b000, 5'd0, 0, 0, 0);

    // Following request (load code) reports no error.
    setch(0, 32'h0000_0001);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("post_ill_load", 3'b001, 5'd0, 1, 0, 0);
    tick();
    chk("post_ill_done", 3'b000, 5'd0, 0, 1, 0);
    tick();

    // Out-of-range select 3 maps to ch0; start held through busy and DONE.
    setch(0, 32'h0000_0002); setch(1, 32'h0000_0005); setch(2, 32'h0000_0004);
    func_sel = 2'd3; amt_sel = 2'd2; step_mode = 1'b0; start = 1'b1;
    tick();
    chk("oor_load", 3'b001, 5'd0, 1, 0, 0);
    tick();
    chk("oor_shift", 3'b010, 5'd4, 1, 0, 0);
    tick();
    chk("oor_done", 3'b000, 5'd0, 0, 1, 0);
    tick();
    chk("oor_start_in_done_ignored", 3'b000, 5'd0, 0, 0, 0);
    start = 1'b0;
    tick();
    chk("oor_single_done", 3'b000, 5'd0, 0, 0, 0);

    // Maximum step amount 31.
    setch(0, 32'h0000_0002); setch(1, 32'h0000_001F);
    func_sel = 2'd0; amt_sel = 2'd1; step_mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("max_load", 3'b001, 5'd0, 1, 0, 0);
    for (int i = 0; i < 31; i++) begin
      tick();
      chk($sformatf("max_shift%0d", i), 3'b010, 5'd1, 1, 0, 0);
    end
    tick();
    chk("max_done", 3'b000, 5'd0, 0, 1, 0);
    tick();
    chk("max_idle", 3'b000, 5'd0, 0, 0, 0);

    // Reset during the second step cycle of amt=31 aborts without done.
    start = 1'b1;
    tick(); start = 1'b0;
    chk("abort_load", 3'b001, 5'd0, 1, 0, 0);
    tick();
    chk("abort_shift1", 3'b010, 5'd1, 1, 0, 0);
    tick();
    chk("abort_shift2", 3'b010, 5'd1, 1, 0, 0);
    reset = 1'b0;
    tick();
    chk("abort_reset", 3'b000, 5'd0, 0, 0, 0);
    reset = 1'b1;
    tick();
    chk("abort_no_done", 3'b000, 5'd0, 0, 0, 0);

    // Fresh request completes normally: step right-arith by 2.
    setch(0, 32'h0000_0004); setch(1, 32'h0000_0002);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("fresh_load", 3'b001, 5'd0, 1, 0, 0);
    tick();
    chk("fresh_shift1", 3'b100, 5'd1, 1, 0, 0);
    tick();
    chk("fresh_shift2", 3'b100, 5'd1, 1, 0, 0);
    tick();
    chk("fresh_done", 3'b000, 5'd0, 0, 1, 0);
    tick();
    chk("fresh_idle", 3'b000, 5'd0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
